// File: rtl/shaper_event_ctrl.sv
// Trapezoid event sequencer: times rise/flat/fall windows, samples energy, rejects pile-up, queues events.
// Optional build macro SHP_BASELINE_EN subtracts a running IDLE baseline from the captured energy.
module shaper_event_ctrl #(
  parameter int K        = 100,
  parameter int L        = 200,
  parameter int PEAK_OFS = 100,
  parameter int HOLDOFF  = 16,
  parameter int DW       = 16,
  parameter int TSW      = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           fast_trig,
  input  logic [DW-1:0]  shp_in,
  input  logic           cnt_clr,
  output logic           shp_rst,
  output logic           busy,
  output logic           ev_valid,
  input  logic           ev_ready,
  output logic [DW-1:0]  ev_energy,
  output logic [TSW-1:0] ev_time,
  output logic [15:0]    pileup_cnt,
  output logic [15:0]    drop_cnt
);

  localparam int WC_MAX = (2*K+L > HOLDOFF) ? 2*K+L : HOLDOFF;
  localparam int WCW    = $clog2(WC_MAX+1);

  localparam logic [WCW-1:0] RISE_LAST = WCW'(K-1);
  localparam logic [WCW-1:0] FLAT_LAST = WCW'(L-1);
  localparam logic [WCW-1:0] PEAK_AT   = WCW'(PEAK_OFS);
  localparam logic [WCW-1:0] PILE_LAST = WCW'(2*K+L-1);
  localparam logic [WCW-1:0] HOLD_LAST = WCW'(HOLDOFF-1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RISE = 3'd1;
  localparam logic [2:0] S_FLAT = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_PILE = 3'd5;

  logic [2:0]           state;
  logic [WCW-1:0]       wc;
  logic [TSW-1:0]       ts;
  logic [TSW-1:0]       t0_p0;
  logic signed [DW-1:0] shp_s;
  logic signed [DW-1:0] cap_val;
  logic signed [DW-1:0] energy_p0;
  logic                 in_pulse;
  logic                 arm;
  logic                 pile_hit;
  logic                 cap_hit;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [1:0]           fcnt;
  logic signed [DW-1:0] fe0;
  logic signed [DW-1:0] fe1;
  logic [TSW-1:0]       ft0;
  logic [TSW-1:0]       ft1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign shp_s    = $signed(shp_in);
  assign in_pulse = (state == S_RISE) || (state == S_FLAT) || (state == S_FALL);
  assign arm      = en && (state == S_IDLE) && fast_trig;
  assign pile_hit = en && fast_trig && in_pulse;
  assign cap_hit  = en && (state == S_FLAT) && (wc == PEAK_AT);
  assign push     = en && (state == S_FALL) && !fast_trig && (wc == RISE_LAST);
  assign pop      = ev_valid && ev_ready;
  assign drop     = push && (fcnt == 2'd2) && !pop;

  assign busy      = (state != S_IDLE);
  assign ev_valid  = (fcnt != 2'd0);
  assign ev_energy = fe0;
  assign ev_time   = ft0;

`ifdef SHP_BASELINE_EN
  logic signed [DW+3:0] bl_acc;
  logic signed [DW-1:0] bl;
  logic signed [DW:0]   diff_p0;

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [DW:0] x);
    if (x[DW] != x[DW-1])
      return x[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return x[DW-1:0];
  endfunction

  // bl_acc holds 16x the baseline so the >>>4 step keeps fractional precision
  assign bl      = bl_acc[DW+3:4];
  assign diff_p0 = {shp_s[DW-1], shp_s} - {bl[DW-1], bl};
  assign cap_val = sat_dw(diff_p0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      bl_acc <= '0;
    else if (state == S_IDLE)
      bl_acc <= bl_acc + (DW+4)'(shp_s) - (DW+4)'(bl);
  end
`else
  assign cap_val = shp_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts      <= '0;
      shp_rst <= 1'b1;
    end else begin
      ts      <= ts + 1'b1;
      shp_rst <= !en;
    end
  end

  // Window sequencer: wc counts cycles spent in the current state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wc    <= '0;
    end else if (!en) begin
      state <= S_IDLE;
      wc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fast_trig) begin
            state <= S_RISE;
            wc    <= '0;
          end
        end
        S_RISE: begin
          if (fast_trig) begin
            state <= S_PILE;
            wc    <= '0;
          end else if (wc == RISE_LAST) begin
            state <= S_FLAT;
            wc    <= '0;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        S_FLAT: begin
          if (fast_trig) begin
            state <= S_PILE;
            wc    <= '0;
          end else if (wc == FLAT_LAST) begin
            state <= S_FALL;
            wc    <= '0;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        S_FALL: begin
          if (fast_trig) begin
            state <= S_PILE;
            wc    <= '0;
          end else if (wc == RISE_LAST) begin
            state <= S_HOLD;
            wc    <= '0;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        S_HOLD: begin
          if (wc == HOLD_LAST) begin
            state <= S_IDLE;
            wc    <= '0;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        S_PILE: begin
          if (fast_trig) begin
            wc <= '0;
          end else if (wc == PILE_LAST) begin
            state <= S_HOLD;
            wc    <= '0;
          end else begin
            wc <= wc + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          wc    <= '0;
        end
      endcase
    end
  end

  // Stage p0: arm timestamp and flat-top energy sample
  always_ff @(posedge clk) begin
    if (arm)
      t0_p0 <= ts;
    if (cap_hit)
      energy_p0 <= cap_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pileup_cnt <= '0;
      drop_cnt   <= '0;
    end else if (cnt_clr) begin
      pileup_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (pile_hit)
        pileup_cnt <= sat_inc(pileup_cnt);
      if (drop)
        drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Two-entry fall-through FIFO; fe0/ft0 is always the head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= 2'd0;
      fe0  <= '0;
      fe1  <= '0;
      ft0  <= '0;
      ft1  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fcnt == 2'd0) begin
            fe0  <= energy_p0;
            ft0  <= t0_p0;
            fcnt <= 2'd1;
          end else if (fcnt == 2'd1) begin
            fe1  <= energy_p0;
            ft1  <= t0_p0;
            fcnt <= 2'd2;
          end
        end
        2'b01: begin
          fe0  <= fe1;
          ft0  <= ft1;
          fcnt <= fcnt - 2'd1;
        end
        2'b11: begin
          if (fcnt == 2'd1) begin
            fe0 <= energy_p0;
            ft0 <= t0_p0;
          end else begin
            fe0 <= fe1;
            ft0 <= ft1;
            fe1 <= energy_p0;
            ft1 <= t0_p0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shaper_event_ctrl.sv
// Bench for shaper_event_ctrl: event-timing model plus directed pulses, pile-up, backpressure, reset/enable.
module tb_shaper_event_ctrl;
  localparam int K        = 4;
  localparam int L        = 8;
  localparam int PEAK_OFS = 4;
  localparam int HOLDOFF  = 2;
  localparam int DW       = 16;
  localparam int TSW      = 32;
  localparam int CAP_REL  = K + 1 + PEAK_OFS;
  localparam int PUSH_REL = 2*K + L;
  localparam int P_IDLE = 0, P_EVT = 1, P_PILE = 2, P_HOLD = 3;

  logic           clk = 1'b0;
  logic           rst, en, fast_trig, cnt_clr, ev_ready;
  logic [DW-1:0]  shp_in;
  logic           shp_rst, busy, ev_valid;
  logic [DW-1:0]  ev_energy;
  logic [TSW-1:0] ev_time;
  logic [15:0]    pileup_cnt, drop_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  bit bl_mode = 1'b0;
  logic [DW-1:0] base = '0;

  // model state
  int          m_phase;
  logic [31:0] m_ts, m_T, m_P, m_hs, m_t0;
  logic [15:0] m_energy, m_pile, m_drop;
  logic        m_shp_rst;
  logic [15:0] q_e[$];
  logic [31:0] q_t[$];

  shaper_event_ctrl #(.K(K), .L(L), .PEAK_OFS(PEAK_OFS), .HOLDOFF(HOLDOFF), .DW(DW), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .en(en), .fast_trig(fast_trig), .shp_in(shp_in), .cnt_clr(cnt_clr),
    .shp_rst(shp_rst), .busy(busy), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_energy(ev_energy), .ev_time(ev_time), .pileup_cnt(pileup_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_to(input int c);
    int g = 0;
    while (m_ts != 32'(c) && g < 4000) begin
      @(negedge clk);
      g++;
    end
    if (m_ts != 32'(c)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_to: ts=%0d required %0d", m_ts, c);
    end
  endtask

  task automatic pulse(input logic [DW-1:0] peak, output int t);
    t = int'(m_ts);
    fast_trig = 1'b1;
    tick();
    fast_trig = 1'b0;
    wait_to(t + CAP_REL);
    shp_in = peak;
    tick();
    shp_in = base;
  endtask

  // Model: event timing expressed in absolute cycle numbers relative to the arming cycle
  initial begin
    logic [31:0] c, rel;
    bit mpop, do_push, do_pile, do_drop;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_phase = P_IDLE; m_ts = '0; m_pile = '0; m_drop = '0; m_shp_rst = 1'b1;
        q_e.delete(); q_t.delete();
      end else begin
        c = m_ts; do_push = 0; do_pile = 0; do_drop = 0;
        mpop = (q_e.size() > 0) && ev_ready;
        if (!en) m_phase = P_IDLE;
        else begin
          case (m_phase)
            P_IDLE: if (fast_trig) begin m_phase = P_EVT; m_T = c; m_t0 = c; end
            P_EVT: begin
              rel = c - m_T;
              if (fast_trig) begin m_phase = P_PILE; m_P = c; do_pile = 1; end
              else begin
                if (rel == 32'(CAP_REL)) m_energy = shp_in;
                if (rel == 32'(PUSH_REL)) begin do_push = 1; m_phase = P_HOLD; m_hs = c + 1; end
              end
            end
            P_PILE: begin
              if (fast_trig) m_P = c;
              else if (c - m_P == 32'(2*K+L)) begin m_phase = P_HOLD; m_hs = c + 1; end
            end
            P_HOLD: if (c - m_hs == 32'(HOLDOFF-1)) m_phase = P_IDLE;
            default: m_phase = P_IDLE;
          endcase
        end
        if (mpop) begin void'(q_e.pop_front()); void'(q_t.pop_front()); end
        if (do_push) begin
          if (q_e.size() < 2) begin q_e.push_back(m_energy); q_t.push_back(m_t0); end
          else do_drop = 1;
        end
        if (cnt_clr) begin m_pile = '0; m_drop = '0; end
        else begin
          if (do_pile && m_pile != 16'hFFFF) m_pile = m_pile + 16'd1;
          if (do_drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
        m_shp_rst = !en;
        m_ts = m_ts + 32'd1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst === 1'b1) begin
        chk("busy", busy, m_phase != P_IDLE);
        chk("shp_rst", shp_rst, m_shp_rst);
        chk("ev_valid", ev_valid, q_e.size() != 0);
        if (q_e.size() != 0) begin
          if (!bl_mode) chk("ev_energy", ev_energy, q_e[0]);
          chk("ev_time", ev_time, q_t[0]);
        end
        chk("pileup_cnt", pileup_cnt, m_pile);
        chk("drop_cnt", drop_cnt, m_drop);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, ta, tb, tc, td, p;
    rst = 1'b0; en = 1'b0; fast_trig = 1'b0; shp_in = '0; cnt_clr = 1'b0; ev_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst shp_rst", shp_rst, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst ev_valid", ev_valid, 1'b0);
    chk("rst ev_energy", ev_energy, 16'd0);
    chk("rst ev_time", ev_time, 32'd0);
    chk("rst pileup", pileup_cnt, 16'd0);
    chk("rst drop", drop_cnt, 16'd0);
    en = 1'b1; rst = 1'b1;

    // single pulse armed at ts=50
    wait_to(50);
    pulse(16'd1000, t);
    wait_to(t + 16); chk("t1 valid@16", ev_valid, 1'b0);
    tick(); chk("t1 valid@17", ev_valid, 1'b1);
    chk("t1 energy", ev_energy, 16'd1000);
    chk("t1 time", ev_time, 32'd50);
    tick(); chk("t1 popped", ev_valid, 1'b0); chk("t1 busy@18", busy, 1'b1);
    tick(); chk("t1 busy@19", busy, 1'b0);

    // pile-up in FLAT, then a clean pulse
    t = int'(m_ts); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(t + 6); fast_trig = 1'b1; tick(); fast_trig = 1'b0; p = t + 6;
    chk("t2 pileup", pileup_cnt, 16'd1);
    wait_to(p + 18); chk("t2 busy@p18", busy, 1'b1);
    tick(); chk("t2 busy@p19", busy, 1'b0); chk("t2 no event", ev_valid, 1'b0);
    pulse(16'd2000, t);
    wait_to(t + 17); chk("t2 energy", ev_energy, 16'd2000); chk("t2 time", ev_time, 32'(t));
    wait_to(t + 19);
    // retrigger inside PILE restarts the window
    t = int'(m_ts); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(t + 2); fast_trig = 1'b1; tick(); fast_trig = 1'b0; p = t + 2;
    wait_to(p + 10); fast_trig = 1'b1; tick(); fast_trig = 1'b0; p = p + 10;
    wait_to(p + 18); chk("t2b busy@p18", busy, 1'b1);
    tick(); chk("t2b busy@p19", busy, 1'b0); chk("t2b pileup", pileup_cnt, 16'd2);

    // backpressure: fill, push+pop while full, then overflow
    ev_ready = 1'b0;
    pulse(16'd111, ta); wait_to(ta + 19);
    pulse(16'd222, tb); wait_to(tb + 19);
    chk("t3 head A", ev_energy, 16'd111); chk("t3 drop0", drop_cnt, 16'd0);
    pulse(16'd333, tc); wait_to(tc + 16); ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("t3 head B", ev_energy, 16'd222); chk("t3 head B time", ev_time, 32'(tb));
    chk("t3 no drop", drop_cnt, 16'd0);
    wait_to(tc + 19);
    pulse(16'd444, td); wait_to(td + 17);
    chk("t3 drop1", drop_cnt, 16'd1); chk("t3 head kept", ev_energy, 16'd222);
    wait_to(td + 19); ev_ready = 1'b1; tick();
    chk("t3 head C", ev_energy, 16'd333); chk("t3 head C time", ev_time, 32'(tc));
    tick(); chk("t3 drained", ev_valid, 1'b0);

    // reset during FLAT with an event held
    ev_ready = 1'b0;
    pulse(16'd555, t); wait_to(t + 19);
    t = int'(m_ts); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(t + 7); rst = 1'b0; #1;
    chk("t4 shp_rst", shp_rst, 1'b1); chk("t4 busy", busy, 1'b0);
    chk("t4 ev_valid", ev_valid, 1'b0); chk("t4 energy", ev_energy, 16'd0);
    chk("t4 time", ev_time, 32'd0); chk("t4 pileup", pileup_cnt, 16'd0);
    chk("t4 drop", drop_cnt, 16'd0);
    tick(); tick(); rst = 1'b1; ev_ready = 1'b1;
    wait_to(20); pulse(16'd777, t);
    wait_to(37); chk("t4 post energy", ev_energy, 16'd777); chk("t4 post time", ev_time, 32'd20);

    // en low during RISE
    wait_to(60); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(62); en = 1'b0; tick();
    chk("t4e shp_rst", shp_rst, 1'b1); chk("t4e busy", busy, 1'b0);
    fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    chk("t4e ignored", busy, 1'b0);
    wait_to(66); chk("t4e shp_rst held", shp_rst, 1'b1);
    en = 1'b1; tick();
    chk("t4e shp_rst rel", shp_rst, 1'b0); chk("t4e pileup", pileup_cnt, 16'd0);
    chk("t4e drop", drop_cnt, 16'd0); chk("t4e no event", ev_valid, 1'b0);

    // saturation and clear priority
    tick();
    force dut.pileup_cnt = 16'hFFFF;
    m_pile = 16'hFFFF;
    #1;
    release dut.pileup_cnt;
    t = int'(m_ts); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(t + 2); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    chk("t6 saturated", pileup_cnt, 16'hFFFF);
    wait_to(t + 21);
    t = int'(m_ts); fast_trig = 1'b1; tick(); fast_trig = 1'b0;
    wait_to(t + 2); fast_trig = 1'b1; cnt_clr = 1'b1; tick(); fast_trig = 1'b0; cnt_clr = 1'b0;
    chk("t6 clr wins", pileup_cnt, 16'd0);
    wait_to(t + 21);

`ifdef SHP_BASELINE_EN
    begin
      int e;
      bl_mode = 1'b1; base = 16'd100; shp_in = 16'd100;
      wait_to(int'(m_ts) + 200);
      pulse(16'd1100, t);
      wait_to(t + 17);
      e = int'($signed(ev_energy));
      n_cmp++;
      if (e < 999 || e > 1001) begin
        n_fail++;
        $display("FAIL t5 baseline energy: got %0d expected 1000+/-1", e);
      end
      wait_to(t + 19);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
